// File: rtl/checkout_tally.sv
// ============================================================================
// checkout_tally : till stage with running total, theft alarm, one-level void
//                  and a double-dabble binary-to-BCD converter for HEX drivers.
// Revision 1.0
// ============================================================================
`default_nettype none

module checkout_tally #(
  parameter int UPC_W      = 3,
  parameter int PRICE_STEP = 5,
  parameter int TOTAL_W    = 13,
  parameter int CNT_W      = 8,
  parameter int DIGITS     = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  scan,
  input  logic [UPC_W-1:0]      upc,
  input  logic                  mark,
  input  logic                  void_last,
  input  logic                  clear,
  output logic [TOTAL_W-1:0]    total,
  output logic [CNT_W-1:0]      items,
  output logic                  alarm,
  output logic                  last_disc,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  bcd_valid
);

  localparam int                 c_CW    = $clog2(TOTAL_W + 1);
  localparam logic [c_CW-1:0]    c_LAST  = c_CW'(TOTAL_W - 1);
  localparam logic [TOTAL_W-1:0] c_STEP  = TOTAL_W'(PRICE_STEP);
  localparam logic [0:0]         c_IDLE  = 1'b0;
  localparam logic [0:0]         c_SHIFT = 1'b1;

  logic                  r_scan_q;
  logic [TOTAL_W-1:0]    r_total;
  logic [CNT_W-1:0]      r_items;
  logic                  r_alarm;
  logic                  r_disc;
  logic [TOTAL_W-1:0]    r_undo_price;
  logic                  r_undo_valid;

  logic                  w_event;
  logic                  w_disc_item;
  logic [TOTAL_W-1:0]    w_list;
  logic [TOTAL_W-1:0]    w_price;
  logic [TOTAL_W:0]      w_sum;
  logic [TOTAL_W-1:0]    w_sat_total;
  logic [TOTAL_W-1:0]    w_sub_total;
  logic [CNT_W:0]        w_cnt_sum;
  logic [CNT_W-1:0]      w_sat_items;
  logic [CNT_W-1:0]      w_sub_items;

  logic [TOTAL_W-1:0]    w_total_nxt;
  logic [CNT_W-1:0]      w_items_nxt;
  logic                  w_alarm_nxt;
  logic                  w_disc_nxt;
  logic                  w_undo_valid_nxt;
  logic                  w_undo_load;
  logic                  w_load;

  assign w_event     = scan & ~r_scan_q;
  assign w_disc_item = upc[UPC_W-1];
  assign w_list      = (TOTAL_W'(upc) + TOTAL_W'(1)) * c_STEP;
  assign w_price     = w_disc_item ? (w_list >> 1) : w_list;

  assign w_sum       = {1'b0, r_total} + {1'b0, w_price};
  assign w_sat_total = w_sum[TOTAL_W] ? '1 : w_sum[TOTAL_W-1:0];
  assign w_sub_total = (r_total >= r_undo_price) ? (r_total - r_undo_price) : '0;
  assign w_cnt_sum   = {1'b0, r_items} + {{CNT_W{1'b0}}, 1'b1};
  assign w_sat_items = w_cnt_sum[CNT_W] ? '1 : w_cnt_sum[CNT_W-1:0];
  assign w_sub_items = (r_items != '0) ? (r_items - CNT_W'(1)) : '0;

  // Priority: clear, then alarm hold, then an effective void, then scan.
  always_comb begin
    w_total_nxt      = r_total;
    w_items_nxt      = r_items;
    w_alarm_nxt      = r_alarm;
    w_disc_nxt       = r_disc;
    w_undo_valid_nxt = r_undo_valid;
    w_undo_load      = 1'b0;
    if (clear) begin
      w_total_nxt      = '0;
      w_items_nxt      = '0;
      w_alarm_nxt      = 1'b0;
      w_disc_nxt       = 1'b0;
      w_undo_valid_nxt = 1'b0;
    end else if (r_alarm) begin
      w_alarm_nxt = 1'b1;
    end else if (void_last && r_undo_valid) begin
      w_total_nxt      = w_sub_total;
      w_items_nxt      = w_sub_items;
      w_disc_nxt       = 1'b0;
      w_undo_valid_nxt = 1'b0;
    end else if (w_event) begin
      if (!mark) begin
        w_alarm_nxt = 1'b1;
      end else begin
        w_total_nxt      = w_sat_total;
        w_items_nxt      = w_sat_items;
        w_disc_nxt       = w_disc_item;
        w_undo_valid_nxt = 1'b1;
        w_undo_load      = 1'b1;
      end
    end
  end

  assign w_load = (w_total_nxt != r_total);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_scan_q     <= 1'b1;
      r_total      <= '0;
      r_items      <= '0;
      r_alarm      <= 1'b0;
      r_disc       <= 1'b0;
      r_undo_price <= '0;
      r_undo_valid <= 1'b0;
    end else begin
      r_scan_q     <= scan;
      r_total      <= w_total_nxt;
      r_items      <= w_items_nxt;
      r_alarm      <= w_alarm_nxt;
      r_disc       <= w_disc_nxt;
      r_undo_valid <= w_undo_valid_nxt;
      if (w_undo_load) begin
        r_undo_price <= w_price;
      end
    end
  end

  // Double-dabble converter; a fresh total always restarts it.
  logic [0:0]            r_state;
  logic [0:0]            w_state_nxt;
  logic [c_CW-1:0]       r_cnt;
  logic [TOTAL_W-1:0]    r_bin;
  logic [4*DIGITS-1:0]   r_work;
  logic [4*DIGITS-1:0]   r_bcd;
  logic                  r_bcd_valid;
  logic [4*DIGITS-1:0]   w_corr;
  logic [4*DIGITS-1:0]   w_dabble;
  logic                  w_unused;
  logic                  w_shift_en;
  logic                  w_done;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_IDLE:  if (w_load) w_state_nxt = c_SHIFT;
      c_SHIFT: begin
        if (w_load)               w_state_nxt = c_SHIFT;
        else if (r_cnt == c_LAST) w_state_nxt = c_IDLE;
      end
      default: w_state_nxt = c_IDLE;
    endcase
  end

  always_comb begin
    w_shift_en = 1'b0;
    w_done     = 1'b0;
    if (r_state == c_SHIFT && !w_load) begin
      w_shift_en = 1'b1;
      w_done     = (r_cnt == c_LAST);
    end
  end

  always_comb begin
    w_corr = r_work;
    for (int i = 0; i < DIGITS; i++) begin
      if (w_corr[4*i +: 4] >= 4'd5) begin
        w_corr[4*i +: 4] = w_corr[4*i +: 4] + 4'd3;
      end
    end
  end

  assign w_dabble = {w_corr[4*DIGITS-2:0], r_bin[TOTAL_W-1]};
  assign w_unused = w_corr[4*DIGITS-1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt       <= '0;
      r_bin       <= '0;
      r_work      <= '0;
      r_bcd       <= '0;
      r_bcd_valid <= 1'b1;
    end else if (w_load) begin
      r_cnt       <= '0;
      r_bin       <= w_total_nxt;
      r_work      <= '0;
      r_bcd_valid <= 1'b0;
    end else if (w_shift_en) begin
      r_cnt  <= r_cnt + c_CW'(1);
      r_bin  <= {r_bin[TOTAL_W-2:0], 1'b0};
      r_work <= w_dabble;
      if (w_done) begin
        r_bcd       <= w_dabble;
        r_bcd_valid <= 1'b1;
      end
    end
  end

  assign total     = r_total;
  assign items     = r_items;
  assign alarm     = r_alarm;
  assign last_disc = r_disc;
  assign bcd       = r_bcd;
  assign bcd_valid = r_bcd_valid;

endmodule

`default_nettype wire

// File: tb/tb_checkout_tally.sv
// ============================================================================
// tb_checkout_tally : directed bench for checkout_tally (steps 5 and 1000).
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_checkout_tally;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        scan, mark, void_last, clear;
  logic [2:0]  upc;
  logic [12:0] total;
  logic [7:0]  items;
  logic        alarm, last_disc, bcd_valid;
  logic [15:0] bcd;

  logic        k_scan, k_mark, k_void, k_clear;
  logic [2:0]  k_upc;
  logic [12:0] k_total;
  logic [7:0]  k_items;
  logic        k_alarm, k_disc, k_valid;
  logic [15:0] k_bcd;

  int checks = 0;
  int errors = 0;
  int k;

  always #5 clk = ~clk;

  checkout_tally dut (
    .clk(clk), .reset_n(reset_n), .scan(scan), .upc(upc), .mark(mark),
    .void_last(void_last), .clear(clear), .total(total), .items(items),
    .alarm(alarm), .last_disc(last_disc), .bcd(bcd), .bcd_valid(bcd_valid)
  );

  checkout_tally #(.PRICE_STEP(1000)) dut_k (
    .clk(clk), .reset_n(reset_n), .scan(k_scan), .upc(k_upc), .mark(k_mark),
    .void_last(k_void), .clear(k_clear), .total(k_total), .items(k_items),
    .alarm(k_alarm), .last_disc(k_disc), .bcd(k_bcd), .bcd_valid(k_valid)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_valid(input bit which, output int n);
    n = 0;
    while (((which ? k_valid : bcd_valid) !== 1'b1) && n < 40) begin
      tick();
      n++;
    end
  endtask

  task automatic do_scan(input logic [2:0] u, input logic m);
    scan = 1'b1; upc = u; mark = m;
    tick();
    scan = 1'b0;
  endtask

  task automatic k_do_scan(input logic [2:0] u);
    k_scan = 1'b1; k_upc = u; k_mark = 1'b1;
    tick();
    k_scan = 1'b0;
    tick();
  endtask

  initial begin
    reset_n = 1'b0;
    scan = 0; mark = 1; void_last = 0; clear = 0; upc = '0;
    k_scan = 0; k_mark = 1; k_void = 0; k_clear = 0; k_upc = '0;
    tick(); tick();
    chk("rst_total", 32'(total), 0);
    chk("rst_items", 32'(items), 0);
    chk("rst_alarm", 32'(alarm), 0);
    chk("rst_disc", 32'(last_disc), 0);
    chk("rst_bcd", 32'(bcd), 0);
    chk("rst_valid", 32'(bcd_valid), 1);
    reset_n = 1'b1;
    tick();

    // upc=2 -> 15
    do_scan(3'd2, 1'b1);
    chk("s1_total", 32'(total), 15);
    chk("s1_items", 32'(items), 1);
    chk("s1_disc", 32'(last_disc), 0);
    chk("s1_valid0", 32'(bcd_valid), 0);
    wait_valid(1'b0, k);
    chk("s1_latency", 32'(k), 13);
    chk("s1_bcd", 32'(bcd), 32'h0015);

    // clear, then discounted items 20 + 15
    clear = 1'b1; tick(); clear = 1'b0;
    chk("clr1_total", 32'(total), 0);
    wait_valid(1'b0, k);
    do_scan(3'd7, 1'b1);
    chk("s7_total", 32'(total), 20);
    chk("s7_disc", 32'(last_disc), 1);
    tick();
    do_scan(3'd5, 1'b1);
    chk("s5_total", 32'(total), 35);
    chk("s5_items", 32'(items), 2);
    chk("s5_disc", 32'(last_disc), 1);
    wait_valid(1'b0, k);
    chk("s5_latency", 32'(k), 13);
    chk("s5_bcd", 32'(bcd), 32'h0035);
    tick();

    // tagged item raises alarm, later activity ignored
    do_scan(3'd1, 1'b0);
    chk("al_alarm", 32'(alarm), 1);
    chk("al_total", 32'(total), 35);
    chk("al_items", 32'(items), 2);
    tick();
    do_scan(3'd3, 1'b1);
    chk("al_ign_total", 32'(total), 35);
    chk("al_ign_items", 32'(items), 2);
    void_last = 1'b1; tick(); void_last = 1'b0;
    chk("al_void_total", 32'(total), 35);
    clear = 1'b1; tick(); clear = 1'b0;
    chk("al_clr_total", 32'(total), 0);
    chk("al_clr_items", 32'(items), 0);
    chk("al_clr_alarm", 32'(alarm), 0);
    chk("al_clr_disc", 32'(last_disc), 0);
    wait_valid(1'b0, k);
    chk("al_clr_latency", 32'(k), 13);
    chk("al_clr_bcd", 32'(bcd), 0);

    // void behaviour
    do_scan(3'd3, 1'b1);
    chk("v_total", 32'(total), 20);
    tick();
    void_last = 1'b1; tick(); void_last = 1'b0;
    chk("v1_total", 32'(total), 0);
    chk("v1_items", 32'(items), 0);
    tick();
    void_last = 1'b1; tick(); void_last = 1'b0;
    chk("v2_total", 32'(total), 0);
    do_scan(3'd3, 1'b1);
    tick();
    do_scan(3'd0, 1'b1);
    chk("v3_total", 32'(total), 25);
    chk("v3_items", 32'(items), 2);
    tick();
    void_last = 1'b1; tick();
    chk("v4_total", 32'(total), 20);
    chk("v4_items", 32'(items), 1);
    tick(); void_last = 1'b0;
    chk("v5_total", 32'(total), 20);
    chk("v5_items", 32'(items), 1);

    // scan held high counts once
    clear = 1'b1; tick(); clear = 1'b0;
    scan = 1'b1; upc = 3'd0; mark = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    scan = 1'b0;
    chk("hold_total", 32'(total), 5);
    chk("hold_items", 32'(items), 1);
    tick();
    wait_valid(1'b0, k);

    // restart mid-conversion
    do_scan(3'd0, 1'b1);
    chk("rs_total1", 32'(total), 10);
    tick(); tick(); tick();
    do_scan(3'd1, 1'b1);
    chk("rs_total2", 32'(total), 20);
    wait_valid(1'b0, k);
    chk("rs_latency", 32'(k), 13);
    chk("rs_bcd", 32'(bcd), 32'h0020);

    // clear wins over simultaneous scan
    clear = 1'b1; scan = 1'b1; upc = 3'd2; mark = 1'b1;
    tick();
    clear = 1'b0; scan = 1'b0;
    chk("cs_total", 32'(total), 0);
    chk("cs_items", 32'(items), 0);
    chk("cs_disc", 32'(last_disc), 0);
    tick();
    clear = 1'b1; scan = 1'b1; mark = 1'b0;
    tick();
    clear = 1'b0; scan = 1'b0; mark = 1'b1;
    chk("cs_alarm", 32'(alarm), 0);
    wait_valid(1'b0, k);

    // large price step with saturation
    k_do_scan(3'd3);
    chk("k1_total", 32'(k_total), 4000);
    k_do_scan(3'd3);
    chk("k2_total", 32'(k_total), 8000);
    k_do_scan(3'd3);
    chk("k3_total", 32'(k_total), 8191);
    chk("k3_items", 32'(k_items), 3);
    k_void = 1'b1; tick(); k_void = 1'b0;
    chk("kv_total", 32'(k_total), 4191);
    chk("kv_items", 32'(k_items), 2);
    wait_valid(1'b1, k);
    chk("kv_bcd", 32'(k_bcd), 32'h4191);
    k_do_scan(3'd3);
    wait_valid(1'b1, k);
    chk("k4_bcd", 32'(k_bcd), 32'h8191);
    k_scan = 1'b1; k_upc = 3'd3; tick(); k_scan = 1'b0;
    chk("k5_total", 32'(k_total), 8191);
    chk("k5_items", 32'(k_items), 4);
    chk("k5_valid", 32'(k_valid), 1);

    // async reset aborts a conversion
    do_scan(3'd4, 1'b1);
    tick(); tick();
    reset_n = 1'b0;
    #2;
    chk("ar_total", 32'(total), 0);
    chk("ar_valid", 32'(bcd_valid), 1);
    chk("ar_bcd", 32'(bcd), 0);
    tick();
    reset_n = 1'b1;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/checkout_tally.md
# checkout_tally

Sequential register/till stage for the store demo: accepts scan events carrying an item code and a security mark. It keeps a running price total and item count, latches a theft alarm, and supports voiding the last item. It also converts the total to packed BCD for the HEX digit drivers. It sits between the switch/key inputs and the seven-segment decoders and supersedes the purely combinational stolen/discount logic.

## Interface
- UPC_W, 3, item code width; 2^UPC_W item codes.
- PRICE_STEP, 5, base price unit; list price = (upc+1)*PRICE_STEP.
- TOTAL_W, 13, running-total width.
- CNT_W, 8, item-count width.
- DIGITS, 4, BCD digits. Required: 10^DIGITS > 2^TOTAL_W-1.
- Required: 2^UPC_W*PRICE_STEP <= 2^TOTAL_W-1.
- clk  in  1  single clock; all state changes on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- scan  in  1  level input; each low-to-high transition is one scan event.
- upc  in  UPC_W  item code, sampled with the scan event.
- mark  in  1  1 = tag deactivated (paid); 0 = tagged item.
- void_last  in  1  level; high cycle removes the last added item (one level of undo).
- clear  in  1  synchronous; zeroes the transaction and clears the alarm.
- total  out  TOTAL_W  running total, saturating.
- items  out  CNT_W  item count, saturating.
- alarm  out  1  latched theft alarm.
- last_disc  out  1  last added item was discounted.
- bcd  out  4*DIGITS  packed BCD of total; digit 0 in bits [3:0].
- bcd_valid  out  1  bcd equals current total.

## Operation
- Edge detect: `scan_q` holds the previous sample of scan and resets to 1. Event = scan & ~scan_q. Scan held high, or high across reset release, is not an event.
- Price: list = (upc+1)*PRICE_STEP. If upc[UPC_W-1]=1 the item is discounted and price = list>>1 (floor).
- Priority per cycle: clear > alarm hold > void_last > scan event.
- clear: total=0, items=0, alarm=0, last_disc=0, undo invalid. Any simultaneous void or scan is dropped.
- alarm=1: all void_last and scan events are ignored until clear or reset.
- Scan event with mark=0:
  - alarm<=1.
  - total, items and last_disc are unchanged.
  - Undo is not modified.
- Scan event with mark=1:
  - total <= min(total+price, 2^TOTAL_W-1).
  - items <= min(items+1, 2^CNT_W-1).
  - last_disc <= discount flag.
  - Stores price as undo value; undo valid.
- void_last with undo valid:
  - total <= total - stored price, floored at 0. The stored price is subtracted even if the add saturated.
  - items <= items-1, floored at 0.
  - last_disc<=0; undo invalid.
- void_last with undo invalid: ignored. void_last is level-sensitive: a second consecutive high cycle finds undo invalid.
- BCD converter FSM, double-dabble:
  - States: IDLE and SHIFT.
  - Any cycle that writes total with a new value loads the converter with that value and enters SHIFT. This includes writes during SHIFT, which restart the conversion.
  - SHIFT runs exactly TOTAL_W shift cycles with add-3 correction, then writes bcd and returns to IDLE.
  - A write that leaves total unchanged (e.g. saturated add) does not restart the converter.

## Timing
- Reset (asynchronous) values: total=0, items=0, alarm=0, last_disc=0, bcd=0, bcd_valid=1, FSM=IDLE, undo invalid.
- scan rising edge sampled at clock edge n: total, items, alarm and last_disc are updated at edge n (1-cycle input-to-output latency).
- Converter load: at the same edge n bcd_valid<=0. bcd holds its old value until completion.
- Conversion: shift edges n+1 … n+TOTAL_W. At edge n+TOTAL_W, bcd is updated and bcd_valid<=1.
- A total change at edge m during SHIFT restarts the count. bcd_valid then stays 0 until edge m+TOTAL_W.
- reset_n low mid-conversion aborts immediately to reset values.

## Test plan
- Reset; scan upc=2, mark=1:
  - total=15, items=1, last_disc=0 one edge later.
  - bcd_valid=0 for 13 cycles, then bcd=0x0015, bcd_valid=1.
- Scan upc=7 (list 40 → price 20), then upc=5 (price 15): total=35, items=2, last_disc=1, final bcd=0x0035.
- Scan upc=1 with mark=0:
  - alarm=1, total unchanged.
  - A subsequent scan of upc=3 is ignored.
  - Then clear: all outputs 0, bcd_valid=1 after 13 cycles.
- Scan upc=3 (total 20), then pulse void_last: total=0, items=0. A second void_last pulse causes no change.
- PRICE_STEP=1000: scan upc=3 three times → 4000, 8000, 8191 (saturated); items=3. void_last → total=4191, items=2.
- Corner cases:
  - scan held high for 10 cycles counts once.
  - A second scan 5 cycles into a conversion restarts it; bcd_valid rises 13 cycles after the second update.
  - clear and a scan event in the same cycle → all zero.
